// File: rtl/datatonum_if.sv
// Read-side handshake between the RAM queue and the code decoder.
// The queue drives data/valid (master); the decoder answers with ready (slave).
interface datatonum_if #(
  parameter int DATA_W = 6
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/datatonum.sv
// datatonum: decoder at the read end of the RAM queue, inverse of the
// button-to-code encoder. Pops codes 11/22/33/44/55 and holds the matching
// one-hot button bit and index for HOLD_CYCLES cycles; any other code is
// reported as a one-cycle code_err pulse.
// Optional feature: define ERR_COUNT_EN to add the saturating err_count port.
module datatonum #(
  parameter int DATA_W      = 6,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  datatonum_if.slave q,
  output logic [4:0] num_onehot,
  output logic [2:0] num_idx,
  output logic       num_valid,
  output logic       code_err,
  output logic       busy
`ifdef ERR_COUNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  // Reject parameter values the hold counter and error counter cannot represent.
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("datatonum: HOLD_CYCLES must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("datatonum: CNT_W must be >= 1");
  end

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state;
  logic [HCW-1:0] hold_cnt;
  logic           dec_legal;
  logic [4:0]     dec_onehot;
  logic [2:0]     dec_idx;
  logic           accept;

  // The decoder only takes a word while idle and never while reset is asserted.
  assign q.in_ready = (state == IDLE) && !rst;
  assign accept     = q.in_valid && q.in_ready;

  // Map the incoming code word to its button bit and index.
  always_comb begin
    dec_legal  = 1'b1;
    dec_onehot = 5'b00000;
    dec_idx    = 3'd0;
    case (q.in_data)
      DATA_W'(11): begin dec_onehot = 5'b00001; dec_idx = 3'd1; end
      DATA_W'(22): begin dec_onehot = 5'b00010; dec_idx = 3'd2; end
      DATA_W'(33): begin dec_onehot = 5'b00100; dec_idx = 3'd3; end
      DATA_W'(44): begin dec_onehot = 5'b01000; dec_idx = 3'd4; end
      DATA_W'(55): begin dec_onehot = 5'b10000; dec_idx = 3'd5; end
      default:     dec_legal = 1'b0;
    endcase
  end

  // Decoder FSM: latch a legal result and hold it, or pulse code_err and stay idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      num_onehot <= 5'b00000;
      num_idx    <= 3'd0;
      num_valid  <= 1'b0;
      code_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      code_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_legal) begin
              state      <= HOLD;
              hold_cnt   <= HOLD_LOAD;
              num_onehot <= dec_onehot;
              num_idx    <= dec_idx;
              num_valid  <= 1'b1;
              busy       <= 1'b1;
            end else begin
              code_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state      <= IDLE;
            num_onehot <= 5'b00000;
            num_idx    <= 3'd0;
            num_valid  <= 1'b0;
            busy       <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ERR_COUNT_EN
  // Count accepted illegal words, sticking at the all-ones value.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (accept && !dec_legal && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_datatonum.sv
// Self-checking bench for datatonum (HOLD_CYCLES=4). A directed vector table,
// a few hand-written handshake sequences and a randomized producer queue are
// checked against a cycles-remaining reference model.
module tb_datatonum;

  localparam int HOLD = 4;
`ifdef ERR_COUNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 8;
`endif
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] num_onehot;
  logic [2:0] num_idx;
  logic       num_valid;
  logic       code_err;
  logic       busy;
`ifdef ERR_COUNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  datatonum_if #(.DATA_W(6)) qif ();

  datatonum #(.DATA_W(6), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .q(qif),
    .num_onehot(num_onehot),
    .num_idx(num_idx),
    .num_valid(num_valid),
    .code_err(code_err),
    .busy(busy)
`ifdef ERR_COUNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: cycles of result display left, current result, error state.
  int         mRemain = 0;
  int         mIdx    = 0;
  bit         mErr    = 1'b0;
  int         mErrCnt = 0;

  typedef struct {
    bit         rst;
    bit         valid;
    logic [5:0] data;
    logic [4:0] onehot;
    logic [2:0] idx;
    bit         nvalid;
    bit         err;
    bit         busy;
    bit         ready;
  } vec_t;

  vec_t vecs[$];

  function automatic bit isLegal(input int code);
    return (code >= 11) && (code <= 55) && (code % 11 == 0);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic modelEdge(input bit r, input bit v, input int d, output bit acc);
    acc  = 1'b0;
    mErr = 1'b0;
    if (r) begin
      mRemain = 0;
      mIdx    = 0;
      mErrCnt = 0;
    end else if (mRemain > 0) begin
      mRemain--;
      if (mRemain == 0) mIdx = 0;
    end else if (v) begin
      acc = 1'b1;
      if (isLegal(d)) begin
        mRemain = HOLD;
        mIdx    = d / 11;
      end else begin
        mErr = 1'b1;
        if (mErrCnt < ERR_MAX) mErrCnt++;
      end
    end
  endtask

  // Drive one cycle's inputs on the falling edge and let them settle.
  task automatic applyStimulus(input bit r, input bit v, input logic [5:0] d);
    @(negedge clk);
    rst          = r;
    qif.in_valid = v;
    qif.in_data  = d;
    #1;
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput();
    logic [4:0] expOnehot;
    expOnehot = (mIdx == 0) ? 5'b00000 : 5'(1 << (mIdx - 1));
    cmp("in_ready", 32'(qif.in_ready), 32'((mRemain == 0) && !rst));
    cmp("num_onehot", 32'(num_onehot), 32'(expOnehot));
    cmp("num_idx", 32'(num_idx), 32'(mIdx));
    cmp("num_valid", 32'(num_valid), 32'(mRemain > 0));
    cmp("busy", 32'(busy), 32'(mRemain > 0));
    cmp("code_err", 32'(code_err), 32'(mErr));
`ifdef ERR_COUNT_EN
    cmp("err_count", 32'(err_count), 32'(mErrCnt));
`endif
  endtask

  task automatic clockEdge(output bit acc);
    @(posedge clk);
    modelEdge(rst, qif.in_valid, int'(qif.in_data), acc);
  endtask

  task automatic addVec(input bit r, input bit v, input int d, input logic [4:0] oh,
                        input int idx, input bit nv, input bit err, input bit ready);
    vec_t x;
    x.rst = r; x.valid = v; x.data = 6'(d);
    x.onehot = oh; x.idx = 3'(idx); x.nvalid = nv; x.err = err; x.busy = nv; x.ready = ready;
    vecs.push_back(x);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit         acc;
    int         idx2Cycles;
    int         idx5Cycles;
    logic [5:0] pend[$];
    int         cyc;
    bit         r;
    bit         v;
    logic [5:0] d;

    qif.in_valid = 1'b0;
    qif.in_data  = 6'd0;

    // Directed vectors: inputs for the cycle, expected outputs seen in that cycle.
    addVec(1, 0, 0,  5'b00000, 0, 0, 0, 0);
    addVec(1, 0, 0,  5'b00000, 0, 0, 0, 0);
    addVec(0, 0, 0,  5'b00000, 0, 0, 0, 1);
    addVec(0, 1, 33, 5'b00000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 5'b00100, 3, 1, 0, 0);
    addVec(0, 0, 0,  5'b00000, 0, 0, 0, 1);
    addVec(0, 1, 7,  5'b00000, 0, 0, 0, 1);
    addVec(0, 1, 0,  5'b00000, 0, 0, 1, 1);
    addVec(0, 1, 56, 5'b00000, 0, 0, 1, 1);
    addVec(0, 0, 0,  5'b00000, 0, 0, 1, 1);
    addVec(0, 0, 0,  5'b00000, 0, 0, 0, 1);
    addVec(0, 1, 11, 5'b00000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) addVec(0, 0, 0, 5'b00001, 1, 1, 0, 0);
    addVec(0, 1, 55, 5'b00000, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) addVec(0, 1, 44, 5'b10000, 5, 1, 0, 0);
    addVec(0, 0, 0,  5'b00000, 0, 0, 0, 1);

    clockEdge(acc);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data);
      cmp($sformatf("vec%0d.in_ready", i), 32'(qif.in_ready), 32'(vecs[i].ready));
      cmp($sformatf("vec%0d.onehot", i), 32'(num_onehot), 32'(vecs[i].onehot));
      cmp($sformatf("vec%0d.idx", i), 32'(num_idx), 32'(vecs[i].idx));
      cmp($sformatf("vec%0d.num_valid", i), 32'(num_valid), 32'(vecs[i].nvalid));
      cmp($sformatf("vec%0d.code_err", i), 32'(code_err), 32'(vecs[i].err));
      cmp($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].busy));
      clockEdge(acc);
    end
`ifdef ERR_COUNT_EN
    cmp("errCountAfterThreeIllegal", 32'(err_count), 32'd3);
`endif

    // 22 then 55 offered continuously: 55 waits until ready returns, nothing lost.
    pend = '{6'd22, 6'd55};
    idx2Cycles = 0;
    idx5Cycles = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, pend.size() > 0, (pend.size() > 0) ? pend[0] : 6'd0);
      checkOutput();
      if (num_idx == 3'd2) idx2Cycles++;
      if (num_idx == 3'd5 && num_onehot == 5'b10000) idx5Cycles++;
      clockEdge(acc);
      if (acc) void'(pend.pop_front());
    end
    cmp("backToBack.idx2Cycles", 32'(idx2Cycles), 32'(HOLD));
    cmp("backToBack.idx5Cycles", 32'(idx5Cycles), 32'(HOLD));
    cmp("backToBack.drained", 32'(pend.size()), 32'd0);

    // Reset two cycles into a hold drops the in-flight result.
    applyStimulus(1'b0, 1'b1, 6'd44); checkOutput(); clockEdge(acc);
    applyStimulus(1'b0, 1'b0, 6'd0);  checkOutput(); clockEdge(acc);
    applyStimulus(1'b1, 1'b0, 6'd0);  checkOutput(); clockEdge(acc);
    applyStimulus(1'b1, 1'b0, 6'd0);  checkOutput(); clockEdge(acc);
    applyStimulus(1'b0, 1'b0, 6'd0);  checkOutput();
    cmp("midHoldReset.num_valid", 32'(num_valid), 32'd0);
    cmp("midHoldReset.in_ready", 32'(qif.in_ready), 32'd1);
    clockEdge(acc);

`ifdef ERR_COUNT_EN
    // Five illegal words saturate a 2-bit error counter at 3.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 6'(60 + (i % 4)));
      checkOutput();
      clockEdge(acc);
    end
    applyStimulus(1'b0, 1'b0, 6'd0);
    checkOutput();
    cmp("errSaturate", 32'(err_count), 32'd3);
    clockEdge(acc);
`endif

    // Randomized producer queue with gaps and occasional resets.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 1) == 1) pend.push_back(6'($urandom_range(1, 5) * 11));
      else pend.push_back(6'($urandom_range(0, 63)));
    end
    cyc = 0;
    while (pend.size() > 0 && cyc < 4000) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = v ? pend[0] : 6'($urandom_range(0, 63));
      applyStimulus(r, v, d);
      checkOutput();
      clockEdge(acc);
      if (acc) void'(pend.pop_front());
      cyc++;
    end
    cmp("random.drained", 32'(pend.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
